merge2_rr_node: RTL and testbench



---
 rtl/noc_pkg.sv | 9 +
 rtl/rr_arb2.sv | 23 ++
 rtl/merge2_rr_node.sv | 68 ++++++
 tb/tb_merge2_rr_node.sv | 127 ++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared flit, select-token and merge-state types for the NoC tree
package noc_pkg;
    localparam int FLIT_W   = 9;
    localparam int ADDR_MSB = 8;
    localparam int ADDR_LSB = 5;
    typedef logic [FLIT_W-1:0] flit_t;
    typedef enum logic {SEL0 = 1'b0, SEL1 = 1'b1} sel_t;
    typedef enum logic {EMPTY, HOLD} merge_state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; the pointer moves past the winner on advance
module rr_arb2
    import noc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       gnt_idx,
    output logic       gnt_valid
);
    sel_t r_prio;
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = (&req) ? r_prio : req[1];
    end
    always_ff @(posedge clk) begin
        if (reset)
            r_prio <= SEL0;
        else if (advance && gnt_valid)
            r_prio <= gnt_idx ? SEL0 : SEL1;
    end
endmodule

// File: rtl/merge2_rr_node.sv
// merge2_rr_node: round-robin merge of two flit channels into one flit channel plus a source token
module merge2_rr_node
    import noc_pkg::*;
#(
    parameter int W = FLIT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in0_data,
    input  logic         in0_valid,
    output logic         in0_ready,
    input  logic [W-1:0] in1_data,
    input  logic         in1_valid,
    output logic         in1_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         s_data,
    output logic         s_valid,
    input  logic         s_ready
);
    merge_state_t r_state, w_state_nxt;
    logic [W-1:0] r_data;
    logic         r_sel;
    logic         r_out_pend, r_s_pend;
    logic         w_out_pend_nxt, w_s_pend_nxt;
    logic         w_free, w_load, w_gnt_idx, w_gnt_valid;
    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       ({in1_valid, in0_valid}),
        .advance   (w_load),
        .gnt_idx   (w_gnt_idx),
        .gnt_valid (w_gnt_valid)
    );
    // The stage may reload in the same cycle its last pending channel completes.
    always_comb begin
        w_free         = !reset && (r_state == EMPTY ||
                         ((!r_out_pend || out_ready) && (!r_s_pend || s_ready)));
        w_load         = w_free && w_gnt_valid;
        in0_ready      = w_load && !w_gnt_idx;
        in1_ready      = w_load && w_gnt_idx;
        out_valid      = r_out_pend && !reset;
        s_valid        = r_s_pend && !reset;
        w_out_pend_nxt = w_load || (r_out_pend && !out_ready);
        w_s_pend_nxt   = w_load || (r_s_pend && !s_ready);
        w_state_nxt    = (w_out_pend_nxt || w_s_pend_nxt) ? HOLD : EMPTY;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= EMPTY;
            r_out_pend <= 1'b0;
            r_s_pend   <= 1'b0;
            r_data     <= '0;
            r_sel      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_out_pend <= w_out_pend_nxt;
            r_s_pend   <= w_s_pend_nxt;
            if (w_load) begin
                r_data <= w_gnt_idx ? in1_data : in0_data;
                r_sel  <= w_gnt_idx;
            end
        end
    end
    assign out_data = r_data;
    assign s_data   = r_sel;
endmodule

// File: tb/tb_merge2_rr_node.sv
// tb_merge2_rr_node: directed stimulus with a reference model and flit/token scoreboards
module tb_merge2_rr_node;
    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] in0_data, in1_data, out_data;
    logic       in0_valid, in0_ready, in1_valid, in1_ready;
    logic       out_valid, out_ready, s_data, s_valid, s_ready;

    merge2_rr_node dut (
        .clk       (clk),
        .reset     (reset),
        .in0_data  (in0_data),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in1_data  (in1_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic       m_op = 1'b0, m_sp = 1'b0, m_prio = 1'b0;
    logic [8:0] q_out[$];
    logic       q_s[$];
    logic       acc0, acc1;
    int         n0, n1;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive, check combinational and held outputs, advance the model.
    task automatic step(input logic rst, input logic v0, input logic [8:0] d0,
                        input logic v1, input logic [8:0] d1,
                        input logic ordy, input logic srdy,
                        output logic a0, output logic a1);
        logic g, ld;
        reset = rst; in0_valid = v0; in0_data = d0; in1_valid = v1; in1_data = d1;
        out_ready = ordy; s_ready = srdy;
        #1;
        g  = (v0 && v1) ? m_prio : v1;
        ld = !rst && (v0 || v1) && (!m_op || ordy) && (!m_sp || srdy);
        a0 = ld && !g;
        a1 = ld && g;
        chk("in0_ready", {8'b0, in0_ready}, {8'b0, a0});
        chk("in1_ready", {8'b0, in1_ready}, {8'b0, a1});
        chk("out_valid", {8'b0, out_valid}, {8'b0, m_op && !rst});
        chk("s_valid", {8'b0, s_valid}, {8'b0, m_sp && !rst});
        if (m_op && !rst) chk("out_data", out_data, q_out[0]);
        if (m_sp && !rst) chk("s_data", {8'b0, s_data}, {8'b0, q_s[0]});
        @(posedge clk);
        if (rst) begin
            m_op = 1'b0; m_sp = 1'b0; m_prio = 1'b0;
            q_out.delete(); q_s.delete();
        end else begin
            if (m_op && ordy) begin m_op = 1'b0; void'(q_out.pop_front()); end
            if (m_sp && srdy) begin m_sp = 1'b0; void'(q_s.pop_front()); end
            if (ld) begin
                q_out.push_back(g ? d1 : d0);
                q_s.push_back(g);
                m_op = 1'b1; m_sp = 1'b1; m_prio = !g;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        // reset with in0 requesting: nothing may be accepted
        step(1, 1, 9'h1A5, 0, 9'h000, 1, 1, acc0, acc1);
        step(1, 1, 9'h1A5, 0, 9'h000, 1, 1, acc0, acc1);
        chk("rst_out_data", out_data, 9'h000);
        chk("rst_s_data", {8'b0, s_data}, 9'h000);
        step(0, 1, 9'h1A5, 0, 9'h000, 1, 1, acc0, acc1);
        chk("first_accept", {8'b0, acc0}, 9'h001);
        step(0, 0, 9'h000, 0, 9'h000, 1, 1, acc0, acc1);
        // both inputs saturating with full downstream readiness
        n0 = 0; n1 = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 9'h180 + 9'(n0), 1, 9'h0C0 + 9'(n1), 1, 1, acc0, acc1);
            chk("tput", {8'b0, acc0 | acc1}, 9'h001);
            n0 += int'(acc0); n1 += int'(acc1);
        end
        chk("alt_count0", 9'(n0), 9'd5);
        chk("alt_count1", 9'(n1), 9'd5);
        step(0, 0, 9'h000, 0, 9'h000, 1, 1, acc0, acc1);
        // lone in1 request, then prio must favour in0
        step(0, 0, 9'h000, 1, 9'h1FF, 1, 1, acc0, acc1);
        step(0, 1, 9'h111, 1, 9'h122, 1, 1, acc0, acc1);
        chk("prio_after_in1", {8'b0, acc0}, 9'h001);
        step(0, 0, 9'h000, 0, 9'h000, 1, 1, acc0, acc1);
        // out back-pressure: token leaves, flit is held, no new acceptance
        step(0, 1, 9'h055, 0, 9'h000, 1, 1, acc0, acc1);
        for (int i = 0; i < 5; i++) step(0, 1, 9'h066, 1, 9'h077, 0, 1, acc0, acc1);
        step(0, 1, 9'h066, 1, 9'h077, 1, 1, acc0, acc1);
        chk("out_bp_reload", {8'b0, acc0 | acc1}, 9'h001);
        step(0, 0, 9'h000, 0, 9'h000, 1, 1, acc0, acc1);
        // token back-pressure: flit leaves first, reload when s_ready rises
        step(0, 1, 9'h0F0, 0, 9'h000, 1, 1, acc0, acc1);
        for (int i = 0; i < 3; i++) step(0, 1, 9'h0F1, 1, 9'h0F2, 1, 0, acc0, acc1);
        step(0, 1, 9'h0F1, 1, 9'h0F2, 1, 1, acc0, acc1);
        chk("s_bp_reload", {8'b0, acc0 | acc1}, 9'h001);
        step(0, 0, 9'h000, 0, 9'h000, 1, 1, acc0, acc1);
        // reset while holding 9'h0AA with prio pointing at in1
        step(0, 1, 9'h0AA, 0, 9'h000, 0, 0, acc0, acc1);
        step(0, 0, 9'h000, 0, 9'h000, 0, 0, acc0, acc1);
        step(1, 1, 9'h0BB, 1, 9'h0CC, 1, 1, acc0, acc1);
        step(0, 0, 9'h000, 0, 9'h000, 1, 1, acc0, acc1);
        step(0, 1, 9'h0DD, 1, 9'h0EE, 1, 1, acc0, acc1);
        chk("prio_after_reset", {8'b0, acc0}, 9'h001);
        step(0, 0, 9'h000, 0, 9'h000, 1, 1, acc0, acc1);
        step(0, 0, 9'h000, 0, 9'h000, 1, 1, acc0, acc1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
